// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between the instruction-fetch
//   path (if_*) and the load/store path (ls_*). One access is in flight at a
//   time; load/store wins arbitration unless fetch has been passed over
//   STARVE_MAX times in a row. A fetch flush suppresses the response of an
//   in-flight fetch.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   if_req/if_addr       fetch request, held until if_gnt
//   if_flush             drop the response of the fetch currently in ACCESS
//   if_gnt/if_valid      fetch accepted / if_rdata valid (one-cycle pulses)
//   if_rdata             last fetched word
//   ls_req/ls_we/ls_addr/ls_wdata   load/store request, held until ls_gnt
//   ls_gnt/ls_valid      load/store accepted / load data valid or store done
//   ls_rdata             last loaded word (stores leave it untouched)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port
//   busy                 an access is in flight (not IDLE)
//
// Every output is a flop; the comb process computes all next values.

module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_valid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT);
  localparam logic [SW-1:0] S_MAX    = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_d;
  logic          owner_if, owner_if_d;   // 1: fetch owns the access
  logic          is_store, is_store_d;   // ls access is a store
  logic [CW-1:0] cnt, cnt_d;
  logic [SW-1:0] streak, streak_d;
  logic          drop, drop_d;

  logic          if_gnt_d, if_valid_d, ls_gnt_d, ls_valid_d;
  logic          mem_en_d, mem_we_d;
  logic [DW-1:0] if_rdata_d, ls_rdata_d, mem_wdata_d;
  logic [AW-1:0] mem_addr_d;
  logic          pick_if, drop_now;

  always_comb begin
    state_d     = state;
    owner_if_d  = owner_if;
    is_store_d  = is_store;
    cnt_d       = cnt;
    streak_d    = streak;
    drop_d      = drop;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    ls_valid_d  = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    if_rdata_d  = if_rdata;
    ls_rdata_d  = ls_rdata;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    pick_if     = 1'b0;
    drop_now    = 1'b0;

    case (state)
      IDLE, RESP: begin
        drop_d = 1'b0;
        if (!if_req) streak_d = '0;
        if (if_req || ls_req) begin
          // Fetch wins only when ls is absent or fetch has been starved.
          pick_if = if_req && (!ls_req || streak == S_MAX);
          state_d  = ACCESS;
          mem_en_d = 1'b1;
          cnt_d    = LAT_LOAD;
          if (pick_if) begin
            if_gnt_d    = 1'b1;
            owner_if_d  = 1'b1;
            is_store_d  = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end else begin
            ls_gnt_d    = 1'b1;
            owner_if_d  = 1'b0;
            is_store_d  = ls_we;
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            if (if_req && streak != S_MAX) streak_d = streak + SW'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        // A flush seen on the capture edge itself still counts.
        drop_now = drop | (owner_if & if_flush);
        drop_d   = drop_now;
        if (cnt == '0) begin
          state_d = RESP;
          drop_d  = 1'b0;
          if (owner_if) begin
            if (!drop_now) begin
              if_valid_d = 1'b1;
              if_rdata_d = mem_rdata;
            end
          end else begin
            ls_valid_d = 1'b1;
            if (!is_store) ls_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner_if  <= 1'b0;
      is_store  <= 1'b0;
      cnt       <= '0;
      streak    <= '0;
      drop      <= 1'b0;
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      ls_valid  <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      owner_if  <= owner_if_d;
      is_store  <= is_store_d;
      cnt       <= cnt_d;
      streak    <= streak_d;
      drop      <= drop_d;
      if_gnt    <= if_gnt_d;
      ls_gnt    <= ls_gnt_d;
      if_valid  <= if_valid_d;
      ls_valid  <= ls_valid_d;
      if_rdata  <= if_rdata_d;
      ls_rdata  <= ls_rdata_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) share
// one stimulus stream. A transaction-level model predicts every output per
// edge from arbitration rules and absolute cycle times; directed sequences
// pin exact values from hand-worked timelines.

module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic if_req = 1'b0, if_flush = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;

  logic [1:0]       if_gnt_o, if_valid_o, ls_gnt_o, ls_valid_o, mem_en_o, mem_we_o, busy_o;
  logic [1:0][31:0] if_rdata_o, ls_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(g == 0 ? 1 : 3), .STARVE_MAX(SMAX)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(if_gnt_o[g]), .if_valid(if_valid_o[g]), .if_rdata(if_rdata_o[g]),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt_o[g]), .ls_valid(ls_valid_o[g]), .ls_rdata(ls_rdata_o[g]),
      .mem_en(mem_en_o[g]), .mem_we(mem_we_o[g]), .mem_addr(mem_addr_o[g]),
      .mem_wdata(mem_wdata_o[g]), .mem_rdata(mem_rdata_i[g]), .busy(busy_o[g])
    );
  end

  function automatic logic [31:0] init_word(input int i, input int k);
    logic [7:0] ib;
    ib = 8'(i);
    if (k == 4) return 32'hDEADBEEF;
    return {16'hA5A5, ib, 6'(k), 2'b00};
  endfunction

  // Memory: 64 words per instance; read data appears MEM_LAT edges after
  // mem_en is sampled, otherwise the bus carries random junk.
  logic [31:0] bmem [2][64];
  logic [31:0] dl   [2][3];
  assign mem_rdata_i[0] = dl[0][0];
  assign mem_rdata_i[1] = dl[1][2];

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        for (int k = 0; k < 64; k++) bmem[i][k] <= init_word(i, k);
      end else if (mem_en_o[i] && mem_we_o[i]) begin
        bmem[i][mem_addr_o[i][7:2]] <= mem_wdata_o[i];
      end
      dl[i][0] <= (mem_en_o[i] && !mem_we_o[i]) ? bmem[i][mem_addr_o[i][7:2]] : $urandom;
      dl[i][1] <= dl[i][0];
      dl[i][2] <= dl[i][1];
    end
  end

  // Reference model state
  int          cyc;
  int          n_chk, n_fail;
  int          m_owner [2];   // 0 none, 1 fetch, 2 load/store
  int          m_cap   [2];   // edge number at which the response lands
  int          m_streak[2];
  bit          m_drop  [2], m_st[2];
  logic [31:0] m_data  [2];
  logic [31:0] ref_mem [2][64];
  logic        e_if_gnt[2], e_if_valid[2], e_ls_gnt[2], e_ls_valid[2];
  logic        e_mem_en[2], e_mem_we[2], e_busy[2];
  logic [31:0] e_if_rdata[2], e_ls_rdata[2], e_mem_addr[2], e_mem_wdata[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = 0; m_cap[i] = 0; m_streak[i] = 0; m_drop[i] = 0; m_st[i] = 0;
      m_data[i] = '0;
      e_if_gnt[i] = 0; e_if_valid[i] = 0; e_ls_gnt[i] = 0; e_ls_valid[i] = 0;
      e_mem_en[i] = 0; e_mem_we[i] = 0; e_busy[i] = 0;
      e_if_rdata[i] = '0; e_ls_rdata[i] = '0; e_mem_addr[i] = '0; e_mem_wdata[i] = '0;
      for (int k = 0; k < 64; k++) ref_mem[i][k] = init_word(i, k);
    end
  endtask

  // Predicts the effect of the coming rising edge from the current inputs.
  task automatic model_edge();
    cyc++;
    if (!rst) return;
    for (int i = 0; i < 2; i++) begin
      int lat;
      lat = (i == 0) ? 1 : 3;
      e_if_gnt[i] = 0; e_ls_gnt[i] = 0; e_if_valid[i] = 0; e_ls_valid[i] = 0;
      e_mem_en[i] = 0; e_mem_we[i] = 0;
      if (m_owner[i] != 0) begin
        if (m_owner[i] == 1 && if_flush) m_drop[i] = 1;
        if (cyc == m_cap[i]) begin
          if (m_owner[i] == 1) begin
            if (!m_drop[i]) begin e_if_valid[i] = 1; e_if_rdata[i] = m_data[i]; end
          end else begin
            e_ls_valid[i] = 1;
            if (!m_st[i]) e_ls_rdata[i] = m_data[i];
          end
          m_owner[i] = 0;
          m_drop[i]  = 0;
        end
        e_busy[i] = 1;
      end else begin
        if (!if_req) m_streak[i] = 0;
        if (!if_req && !ls_req) begin
          e_busy[i] = 0;
        end else begin
          if (ls_req && !(if_req && m_streak[i] == SMAX)) begin
            e_ls_gnt[i] = 1; e_mem_we[i] = ls_we;
            e_mem_addr[i] = ls_addr; e_mem_wdata[i] = ls_wdata;
            m_owner[i] = 2; m_st[i] = ls_we;
            if (ls_we) ref_mem[i][ls_addr[7:2]] = ls_wdata;
            m_data[i] = ref_mem[i][ls_addr[7:2]];
            m_streak[i] = if_req ? ((m_streak[i] < SMAX) ? m_streak[i] + 1 : SMAX) : 0;
          end else begin
            e_if_gnt[i] = 1; e_mem_we[i] = 0;
            e_mem_addr[i] = if_addr; e_mem_wdata[i] = '0;
            m_owner[i] = 1; m_st[i] = 0;
            m_data[i] = ref_mem[i][if_addr[7:2]];
            m_streak[i] = 0;
          end
          e_mem_en[i] = 1;
          m_cap[i]  = cyc + 1 + lat;
          e_busy[i] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got %h expected %h", nm, inst, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("if_gnt",    i, if_gnt_o[i],    e_if_gnt[i]);
      chk("if_valid",  i, if_valid_o[i],  e_if_valid[i]);
      chk("if_rdata",  i, if_rdata_o[i],  e_if_rdata[i]);
      chk("ls_gnt",    i, ls_gnt_o[i],    e_ls_gnt[i]);
      chk("ls_valid",  i, ls_valid_o[i],  e_ls_valid[i]);
      chk("ls_rdata",  i, ls_rdata_o[i],  e_ls_rdata[i]);
      chk("mem_en",    i, mem_en_o[i],    e_mem_en[i]);
      chk("mem_we",    i, mem_we_o[i],    e_mem_we[i]);
      chk("mem_addr",  i, mem_addr_o[i],  e_mem_addr[i]);
      chk("mem_wdata", i, mem_wdata_o[i], e_mem_wdata[i]);
      chk("busy",      i, busy_o[i],      e_busy[i]);
      chk("gnt_excl",  i, if_gnt_o[i] & ls_gnt_o[i], 0);
      chk("vld_excl",  i, if_valid_o[i] & ls_valid_o[i], 0);
    end
  endtask

  // One rising edge; outputs compared at the following falling edge.
  task automatic step();
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    if_req = 0; ls_req = 0; if_flush = 0; ls_we = 0;
    step();
    step();
    rst = 1'b1;
  endtask

  int g_cyc[$];
  bit g_if[$];

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    model_reset();
    @(negedge clk);

    // Single load, then store, then load back of the stored word (MEM_LAT=1).
    do_reset();
    ls_req = 1; ls_we = 0; ls_addr = 32'h10;
    step();  // c1
    chk("t1_ls_gnt", 0, ls_gnt_o[0], 1); chk("t1_mem_en", 0, mem_en_o[0], 1);
    chk("t1_busy_c1", 0, busy_o[0], 1);
    ls_req = 0;
    step();  // c2
    chk("t1_busy_c2", 0, busy_o[0], 1); chk("t1_no_vld_c2", 0, ls_valid_o[0], 0);
    step();  // c3
    chk("t1_ls_valid", 0, ls_valid_o[0], 1); chk("t1_ls_rdata", 0, ls_rdata_o[0], 32'hDEADBEEF);
    chk("t1_busy_c3", 0, busy_o[0], 1);
    ls_req = 1; ls_we = 1; ls_addr = 32'h8; ls_wdata = 32'h12345678;
    step();  // c4: granted back-to-back from RESP
    chk("st_gnt", 0, ls_gnt_o[0], 1); chk("st_mem_en", 0, mem_en_o[0], 1);
    chk("st_mem_we", 0, mem_we_o[0], 1); chk("st_wdata", 0, mem_wdata_o[0], 32'h12345678);
    chk("st_addr", 0, mem_addr_o[0], 32'h8);
    ls_req = 0; ls_we = 0;
    step();  // c5
    step();  // c6
    chk("st_valid", 0, ls_valid_o[0], 1); chk("st_rdata_kept", 0, ls_rdata_o[0], 32'hDEADBEEF);
    ls_req = 1; ls_addr = 32'h8;
    step();  // c7
    ls_req = 0;
    step();  // c8
    step();  // c9
    chk("ld_back_valid", 0, ls_valid_o[0], 1); chk("ld_back_rdata", 0, ls_rdata_o[0], 32'h12345678);
    step();  // c10
    chk("idle_busy", 0, busy_o[0], 0);

    // Fetch flush.
    do_reset();
    if_req = 1; if_addr = 32'h24;
    step();  // c1
    chk("f_gnt1", 0, if_gnt_o[0], 1); chk("f_addr1", 0, mem_addr_o[0], 32'h24);
    chk("f_wdata0", 0, mem_wdata_o[0], 0);
    if_addr = 32'h20;
    step();  // c2
    step();  // c3
    chk("f_valid1", 0, if_valid_o[0], 1); chk("f_rdata1", 0, if_rdata_o[0], 32'hA5A50024);
    step();  // c4
    chk("f_gnt2", 0, if_gnt_o[0], 1); chk("f_addr2", 0, mem_addr_o[0], 32'h20);
    if_addr = 32'h28; if_flush = 1;
    step();  // c5
    if_flush = 0;
    chk("f_novld_c5", 0, if_valid_o[0], 0);
    step();  // c6
    chk("f_novld_c6", 0, if_valid_o[0], 0); chk("f_rdata_kept", 0, if_rdata_o[0], 32'hA5A50024);
    step();  // c7
    chk("f_gnt3", 0, if_gnt_o[0], 1); chk("f_addr3", 0, mem_addr_o[0], 32'h28);
    if_req = 0;
    step();  // c8
    step();  // c9
    chk("f_valid3", 0, if_valid_o[0], 1); chk("f_rdata3", 0, if_rdata_o[0], 32'hA5A50028);

    // Starvation guard: both requesters always pending.
    do_reset();
    if_req = 1; if_addr = 32'h40;
    ls_req = 1; ls_we = 1; ls_addr = 32'h44; ls_wdata = 32'h0BADF00D;
    for (int t = 1; t <= 30; t++) begin
      step();
      if (ls_gnt_o[0]) begin
        g_cyc.push_back(t); g_if.push_back(1'b0);
        ls_we = 0; ls_addr = ls_addr + 32'h4;
      end
      if (if_gnt_o[0]) begin
        g_cyc.push_back(t); g_if.push_back(1'b1);
        if_addr = if_addr + 32'h4;
      end
    end
    if_req = 0; ls_req = 0;
    chk("sv_count", 0, g_cyc.size(), 10);
    for (int k = 0; k < 10 && k < g_cyc.size(); k++) begin
      chk("sv_kind", 0, g_if[k], (k % 5 == 4) ? 1 : 0);
      chk("sv_cycle", 0, g_cyc[k], 1 + 3 * k);
    end
    for (int t = 0; t < 8; t++) step();

    // Reset during an in-flight fetch on the MEM_LAT=3 instance.
    do_reset();
    if_req = 1; if_addr = 32'h30;
    step();  // c1
    chk("r_gnt", 1, if_gnt_o[1], 1);
    step();  // c2
    #2 rst = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("r0_flags", i, {if_gnt_o[i], if_valid_o[i], ls_gnt_o[i], ls_valid_o[i],
                          mem_en_o[i], mem_we_o[i], busy_o[i]}, 0);
      chk("r0_if_rdata", i, if_rdata_o[i], 0);
      chk("r0_ls_rdata", i, ls_rdata_o[i], 0);
      chk("r0_mem_addr", i, mem_addr_o[i], 0);
      chk("r0_mem_wdata", i, mem_wdata_o[i], 0);
    end
    step();
    rst = 1'b1;
    step();  // first edge after release
    chk("r_regnt", 1, if_gnt_o[1], 1); chk("r_regnt_addr", 1, mem_addr_o[1], 32'h30);
    if_req = 0;
    for (int t = 0; t < 3; t++) begin
      step();
      chk("r_no_stale_vld", 1, if_valid_o[1], 0);
    end
    step();
    chk("r_new_vld", 1, if_valid_o[1], 1); chk("r_new_rdata", 1, if_rdata_o[1], 32'hA5A50130);

    // Randomized traffic.
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      step();
      if (!if_req || if_gnt_o[0]) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = 32'($urandom_range(0, 63)) << 2;
      end else if ($urandom_range(0, 49) == 0) begin
        if_req = 0;
      end
      if (!ls_req || ls_gnt_o[0]) begin
        ls_req   = ($urandom_range(0, 2) != 0);
        ls_we    = $urandom_range(0, 1) == 1;
        ls_addr  = 32'($urandom_range(0, 63)) << 2;
        ls_wdata = $urandom;
      end else if ($urandom_range(0, 49) == 0) begin
        ls_req = 0;
      end
      if_flush = ($urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: the instruction-fetch path and the load/store path (LDR/STR).
- Sits between fetch/controller logic and the unified memory. One access in flight at a time, fixed memory read latency.
- Load/store has priority. A starvation guard guarantees fetch progress. A fetch flush discards a stale fetch response after a taken branch.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, memory cycles from sampled mem_en to valid mem_rdata (>=1).
- STARVE_MAX, 4, consecutive load/store grants allowed while if_req is pending.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  AW  fetch address.
- if_flush  in  1  cancel response of an in-flight fetch.
- if_gnt  out  1  one-cycle pulse: fetch accepted.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DW  fetched word.
- ls_req  in  1  load/store request; held with ls_we/ls_addr/ls_wdata until ls_gnt.
- ls_we  in  1  1=store, 0=load.
- ls_addr  in  AW  data address.
- ls_wdata  in  DW  store data.
- ls_gnt  out  1  one-cycle pulse: load/store accepted.
- ls_valid  out  1  one-cycle pulse: load data valid / store complete.
- ls_rdata  out  DW  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  access in flight (state != IDLE).

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0, including rdata regs, mem_addr and mem_wdata; streak counter 0; in-flight access abandoned with no valid pulse. Release is synchronous to the next clk edge.
- States: IDLE, ACCESS, RESP. All outputs are registered.
- Arbitration at edge E, in IDLE or RESP:
  - If neither request is pending: go to IDLE.
  - Winner is ls, unless if_req=1 and streak==STARVE_MAX, in which case the winner is if.
  - Winner actions: go to ACCESS; winner gnt=1 for the cycle after E; mem_en=1 for one cycle; mem_we = ls_we (0 for fetch); mem_addr/mem_wdata latched from the winner (mem_wdata=0 for fetch); owner and wait counter latched.
- Streak counter:
  - Increments on an ls grant while if_req=1, saturating at STARVE_MAX.
  - Clears on an if grant or whenever if_req=0 at an arbitration edge.
- ACCESS:
  - mem_en deasserts after one cycle.
  - Counter runs MEM_LAT cycles after the edge at which memory sampled mem_en.
  - At edge E+1+MEM_LAT: capture mem_rdata into owner's rdata (stores leave ls_rdata unchanged); owner valid=1 for one cycle; go to RESP.
- RESP: valid drops; arbitrates as above (back-to-back). Grant period is MEM_LAT+2 cycles.
- Flush:
  - if_flush=1 in any cycle while owner=if and state=ACCESS sets a drop flag.
  - At capture with drop set: if_valid stays 0 and if_rdata is unchanged.
  - Drop flag clears on entering RESP.
  - if_flush has no effect on ls accesses or in IDLE/RESP.
- Requests are never granted while busy in ACCESS. A req dropped before gnt is simply not served, with no error.
- if_gnt and ls_gnt are never high together. if_valid and ls_valid are never high together.

Test Plan:
- MEM_LAT=1, single load ls_addr=0x10, memory returns 0xDEADBEEF:
  - ls_gnt at cycle 1, mem_en high cycle 1.
  - ls_valid at cycle 3 with ls_rdata=0xDEADBEEF.
  - busy high cycles 1-3.
- if_req and ls_req both held continuously (store then loads), STARVE_MAX=4:
  - Grant order is ls,ls,ls,ls,if,ls,...
  - Grants exactly 3 cycles apart.
  - No simultaneous gnt.
- Fetch of 0x20 in flight, if_flush pulsed the cycle after if_gnt:
  - No if_valid.
  - if_rdata keeps its old value.
  - Next request still granted in RESP.
- Store ls_we=1, addr 0x8, data 0x12345678:
  - mem_we=1, mem_wdata=0x12345678 with mem_en.
  - ls_valid pulse with ls_rdata unchanged.
- MEM_LAT=3, fetch in flight, rst low at the cycle after if_gnt:
  - All outputs 0 immediately.
  - No if_valid after release.
  - Pending if_req is re-granted at the first arbitration edge after rst rises.
